fetch_queue: RTL and testbench

- Parametrised fetch front-end for the pipelined RISC-V core.
- Replaces the bare PCF/InstrF fetch stage with a PC generator and a DEPTH-entry instruction queue.
- Sits between instruction memory (fixed 1-cycle read latency) and the decode stage, which consumes through a valid/ready handshake.
- Taken branches and jumps resolved in EX drive a redirect that flushes everything in flight.

---
 rtl/fetch_queue.sv | 112 +++++++++++
 tb/tb_fetch_queue.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Fetch front-end: PC generator, one-deep outstanding imem request and a DEPTH-entry instruction queue.
// Optional same-cycle bypass of an arriving word into an empty queue: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
    parameter int unsigned          XLEN     = 32,
    parameter int unsigned          DEPTH    = 4,
    parameter logic [XLEN-1:0]      RESET_PC = '0,
    localparam int unsigned         PW       = $clog2(DEPTH),
    localparam int unsigned         CW       = PW + 1
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pcplus4_d,
    output logic [CW-1:0]   count
);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    logic            pending_q, pending_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;

    logic [31:0]     instr_mem_q [DEPTH];
    logic [XLEN-1:0] pc_mem_q    [DEPTH];

    logic [CW:0]     in_flight;
    logic            bypass_hit;
    logic            push;
    logic            pop;

    // Credit counts the queue plus the one response that may still arrive.
    assign in_flight = (CW+1)'(count_q) + (CW+1)'(pending_q);
    assign imem_req  = reset && !redirect_valid && (in_flight < (CW+1)'(DEPTH));
    assign imem_addr = fetch_pc_q;
    assign count     = count_q;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass_hit = (count_q == '0) && pending_q && !redirect_valid;
`else
    assign bypass_hit = 1'b0;
`endif

    assign instr_valid = ((count_q != '0) || bypass_hit) && !redirect_valid;
    assign pop         = instr_valid && instr_ready && (count_q != '0);
    // A bypassed word that decode accepts at once never occupies an entry.
    assign push        = pending_q && !redirect_valid && !(bypass_hit && instr_ready);

    assign instr_d   = bypass_hit ? imem_rdata : instr_mem_q[rd_ptr_q];
    assign pc_d      = bypass_hit ? pend_pc_q  : pc_mem_q[rd_ptr_q];
    assign pcplus4_d = pc_d + XLEN'(4);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        pend_pc_d  = pend_pc_q;
        pending_d  = pending_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
            pending_d  = 1'b0;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end else begin
            pending_d = imem_req;
            if (imem_req) begin
                pend_pc_d  = fetch_pc_q;
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            pend_pc_q  <= '0;
            pending_q  <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            pend_pc_q  <= pend_pc_d;
            pending_q  <= pending_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only read once count covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= imem_rdata;
            pc_mem_q[wr_ptr_q]    <= pend_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: fill/drain, redirects, PC wrap and mid-stream reset.
module tb_fetch_queue;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [31:0]     imem_rdata = 32'hDEAD_BEEF;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            instr_valid;
    logic            instr_ready;
    logic [31:0]     instr_d;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] pcplus4_d;
    logic [CW-1:0]   count;

    int n_total = 0;
    int n_bad   = 0;
    logic [XLEN-1:0] exp_q[$];

    always #5 clk = ~clk;

    fetch_queue #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_d        (instr_d),
        .pc_d           (pc_d),
        .pcplus4_d      (pcplus4_d),
        .count          (count)
    );

    function automatic logic [31:0] word_at(input logic [XLEN-1:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    // Instruction memory with one-cycle read latency.
    always @(posedge clk) imem_rdata <= imem_req ? word_at(imem_addr) : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every accepted head must match the next expected PC.
    always @(negedge clk) begin
        if (reset) begin
            chk("no_overflow", 32'(dut.push && (count == 3'd4)), 32'd0);
            if (instr_valid && instr_ready) begin
                chk("pop_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    logic [XLEN-1:0] e;
                    e = exp_q.pop_front();
                    chk("pop_pc", pc_d, e);
                    chk("pop_instr", instr_d, word_at(e));
                    chk("pop_pcplus4", pcplus4_d, e + 32'd4);
                end
            end
        end
    end

    logic [CW-1:0] a_cnt  [1:6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    logic          a_req  [1:6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0]   a_addr [1:6] = '{32'd4, 32'd8, 32'd12, 32'd16, 32'd16, 32'd16};
    logic [CW-1:0] d_cnt  [7:13] = '{3'd4, 3'd3, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2};
    logic          d_req  [7:13] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [31:0]   d_addr [7:13] = '{32'd16, 32'd16, 32'd20, 32'd24, 32'd28, 32'd32, 32'd36};

    initial begin
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;

        repeat (2) step();
        #1;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_addr", imem_addr, 32'd0);

        // Fill with decode stalled.
        step(); reset = 1'b1; #1;
        chk("c0_req", 32'(imem_req), 32'd1);
        chk("c0_addr", imem_addr, 32'd0);
        chk("c0_valid", 32'(instr_valid), 32'd0);
        for (int i = 0; i < 10; i++) exp_q.push_back(32'(4 * i));
        for (int c = 1; c <= 6; c++) begin
            step(); #1;
            chk("fill_count", 32'(count), 32'(a_cnt[c]));
            chk("fill_req", 32'(imem_req), 32'(a_req[c]));
            chk("fill_addr", imem_addr, a_addr[c]);
        end
        chk("full_valid", 32'(instr_valid), 32'd1);
        chk("full_head", pc_d, 32'd0);

        // Drain and resume streaming.
        for (int c = 7; c <= 13; c++) begin
            step();
            if (c == 7) instr_ready = 1'b1;
            #1;
            chk("drain_count", 32'(count), 32'(d_cnt[c]));
            chk("drain_req", 32'(imem_req), 32'(d_req[c]));
            chk("drain_addr", imem_addr, d_addr[c]);
        end

        // Stall again, then redirect to 0x100 with three queued and one pending.
        step(); instr_ready = 1'b0; #1;
        chk("c14_addr", imem_addr, 32'd40);
        step(); redirect_valid = 1'b1; redirect_pc = 32'h100; #1;
        chk("r_req", 32'(imem_req), 32'd0);
        chk("r_valid", 32'(instr_valid), 32'd0);
        chk("r_count_before", 32'(count), 32'd3);
        chk("r_left", 32'(exp_q.size()), 32'd3);
        exp_q.delete();
        for (int i = 0; i < 6; i++) exp_q.push_back(32'h100 + 32'(4 * i));
        step(); redirect_valid = 1'b0; #1;
        chk("r1_count", 32'(count), 32'd0);
        chk("r1_req", 32'(imem_req), 32'd1);
        chk("r1_addr", imem_addr, 32'h100);
        chk("r1_valid", 32'(instr_valid), 32'd0);
        step(); #1;
        chk("r2_valid", 32'(instr_valid), 32'd0);
        chk("r2_addr", imem_addr, 32'h104);
        step(); instr_ready = 1'b1; #1;
        chk("r3_valid", 32'(instr_valid), 32'd1);
        chk("r3_pc", pc_d, 32'h100);
        chk("r3_pcplus4", pcplus4_d, 32'h104);
        chk("r3_count", 32'(count), 32'd1);
        repeat (3) step();

        // Back-to-back redirects, last one (misaligned 0x203) wins.
        step(); redirect_valid = 1'b1; redirect_pc = 32'h300; #1;
        chk("b_left", 32'(exp_q.size()), 32'd2);
        exp_q.delete();
        step(); redirect_pc = 32'h203; #1;
        chk("b_req", 32'(imem_req), 32'd0);
        chk("b_valid", 32'(instr_valid), 32'd0);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h200 + 32'(4 * i));
        step(); redirect_valid = 1'b0; #1;
        chk("b1_addr", imem_addr, 32'h200);
        step();
        step(); #1;
        chk("b3_valid", 32'(instr_valid), 32'd1);
        chk("b3_pc", pc_d, 32'h200);
        chk("b3_pcplus4", pcplus4_d, 32'h204);
        repeat (2) step();

        // Wrap of the 32-bit PC.
        step(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
        chk("w_left", 32'(exp_q.size()), 32'd1);
        exp_q.delete();
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0004);
        step(); redirect_valid = 1'b0; #1;
        chk("w1_addr", imem_addr, 32'hFFFF_FFFC);
        step(); #1;
        chk("w2_addr", imem_addr, 32'h0000_0000);
        step(); #1;
        chk("w3_pc", pc_d, 32'hFFFF_FFFC);
        chk("w3_pcplus4", pcplus4_d, 32'h0000_0000);
        repeat (2) step();

        // Asynchronous reset mid-stream with a request in flight.
        step(); reset = 1'b0; #1;
        chk("e_left", 32'(exp_q.size()), 32'd0);
        chk("e_req", 32'(imem_req), 32'd0);
        chk("e_valid", 32'(instr_valid), 32'd0);
        chk("e_count", 32'(count), 32'd0);
        chk("e_addr", imem_addr, 32'd0);
        step();
        step(); reset = 1'b1; #1;
        chk("e0_addr", imem_addr, 32'd0);
        chk("e0_valid", 32'(instr_valid), 32'd0);
        for (int i = 0; i < 3; i++) exp_q.push_back(32'(4 * i));
        step(); #1;
        chk("e1_valid", 32'(instr_valid), 32'd0);
        step(); #1;
        chk("e2_valid", 32'(instr_valid), 32'd1);
        chk("e2_pc", pc_d, 32'd0);
        chk("e2_instr", instr_d, 32'hA5A5_5A5A);
        repeat (3) step();
        chk("e_done", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
